dac_multi: RTL
==============

DAC_MULTI -- requirements
Module: dac_multi

Interface
REQ-001 WIDTH, default 8, SHALL set the code width per channel, in bits, minimum 2.
REQ-002 CH, default 4, SHALL set the number of output channels, minimum 1.
REQ-003 SETTLE_CYC, default 2, SHALL set the cycles from an accepted update to a valid analog output, minimum 1.
REQ-004 VREF, default 3.3, SHALL be a real parameter giving the full-scale reference in volts.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-007 en  in  1  SHALL be the block enable.
REQ-008 in_valid  in  1  SHALL mark a channel write request.
REQ-009 in_ready  out  1  SHALL accept a write; a write occurs when in_valid and in_ready are both high.
REQ-010 in_ch  in  max(1,$clog2(CH))  SHALL be the target channel index.
REQ-011 in_data  in  WIDTH  SHALL be the unsigned code to write.
REQ-012 ldac  in  1  SHALL be the update strobe for all channels.
REQ-013 busy  out  1  SHALL be high while settling is in progress.
REQ-014 ch_err  out  1  SHALL be a sticky flag for writes to an out-of-range channel.
REQ-015 code_out  out  CH*WIDTH  SHALL carry the active codes, with channel c at bits [c*WIDTH +: WIDTH].
REQ-016 a_out  out  real[CH]  SHALL carry the analog output voltage of each channel.

Function
REQ-017 Each channel SHALL hold two registers: a holding code and an active code (double buffering).
REQ-018 in_ready SHALL equal en, and writes SHALL be accepted during SETTLE.
REQ-019 An accepted write with in_ch < CH SHALL load in_data into that channel's holding register only.
REQ-020 An accepted write with in_ch >= CH SHALL be dropped and SHALL set ch_err, which stays set until reset.
REQ-021 The FSM SHALL have two states, IDLE and SETTLE.
REQ-022 In IDLE, ldac=1 with en=1 SHALL copy every holding code to its active code, load the counter with SETTLE_CYC-1, and move to SETTLE.
REQ-023 In SETTLE, the counter SHALL decrement each cycle that en=1; at count 0 the block SHALL update all a_out and return to IDLE.
REQ-024 In SETTLE, the counter and state SHALL freeze while en=0.
REQ-025 busy SHALL be high exactly while the state is SETTLE.
REQ-026 ldac sampled at edge k SHALL update a_out at edge k+SETTLE_CYC; code_out SHALL update at edge k.
REQ-027 ldac in SETTLE, or ldac while en=0, SHALL be ignored and not queued.
REQ-028 When a write and ldac occur in the same cycle, the active code SHALL take the old holding value, and the new value SHALL remain in holding.
REQ-029 a_out[c] SHALL equal VREF*active_code[c]/2**WIDTH, computed in real arithmetic.
REQ-030 a_out SHALL hold its value between updates.

Reset
REQ-031 On rst_n low, the state SHALL go to IDLE, the counter to 0, busy to 0, and ch_err to 0, immediately and independently of clk.
REQ-032 On rst_n low, all holding and active codes SHALL take the reset code, and a_out SHALL equal the reset code's voltage.
REQ-033 Reset during SETTLE SHALL abort the pending update, with no stale output after release.

Configuration
REQ-034 Macro DAC_MIDSCALE_RESET_EN defined SHALL make the reset code 2**(WIDTH-1), giving a_out = VREF/2.
REQ-035 Macro DAC_MIDSCALE_RESET_EN undefined SHALL make the reset code 0, giving a_out = 0.0.

Structure
REQ-036 Package dac_pkg SHALL hold the state enum (IDLE, SETTLE) and a function converting a code, width and reference voltage to a real voltage.
REQ-037 Sub-module dac_channel SHALL implement one channel's holding and active registers and its a_out update, instantiated CH times.

Verification
REQ-038 Reset, default parameters, macro undefined -> every a_out = 0.0, busy=0, in_ready=0 while en=0.
REQ-039 Write ch0=8'hFF and ch3=8'h80, then ldac -> code_out updates at the ldac edge; 2 cycles later a_out[0]=3.2871 and a_out[3]=1.65.
REQ-040 Write ch1=8'h40 in the same cycle as ldac -> active code stays at its old value; a following ldac gives a_out[1]=0.825.
REQ-041 With CH=3, write to in_ch=3 -> ch_err=1 and no channel changes; ch_err stays set until rst_n=0.
REQ-042 Second ldac while busy, plus en=0 for 3 cycles during SETTLE -> second ldac ignored; a_out updates exactly 3 cycles late.
REQ-043 Macro defined, rst_n asserted mid-SETTLE -> every a_out = 1.65 and busy=0 immediately, with no later update.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and helpers for the multi-channel DAC model.
package dac_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Ideal transfer: vref * code / 2**width.
    function automatic real code_to_volt(input logic [63:0] code, input int width, input real vref);
        return vref * real'(code) / real'(64'd1 << width);
    endfunction

endpackage

// File: rtl/dac_multi_if.sv
// Write-request channel of dac_multi: valid/ready plus channel index and code.
interface dac_multi_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [CHW-1:0]   in_ch;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, in_ch, in_data, input  in_ready);
    modport slave  (input  in_valid, in_ch, in_data, output in_ready);
endinterface

// File: rtl/dac_channel.sv
// One DAC channel: holding/active code pair and the settled analog output.
module dac_channel
    import dac_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter real              VREF     = 3.3,
    parameter logic [WIDTH-1:0] RST_CODE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    input  logic             upd,
    output logic [WIDTH-1:0] code,
    output real              a_out
);
    logic [WIDTH-1:0] hold;

    // load samples the pre-write holding value, so a simultaneous write stays buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold  <= RST_CODE;
            code  <= RST_CODE;
            a_out <= code_to_volt(64'(RST_CODE), WIDTH, VREF);
        end else begin
            if (wr)   hold  <= wr_data;
            if (load) code  <= hold;
            if (upd)  a_out <= code_to_volt(64'(code), WIDTH, VREF);
        end
    end
endmodule

// File: rtl/dac_multi.sv
// Double-buffered multi-channel DAC with a global ldac strobe and settle delay.
// Define DAC_MIDSCALE_RESET_EN to reset all channels to mid-scale instead of zero.
module dac_multi
    import dac_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  CH         = 4,
    parameter int  SETTLE_CYC = 2,
    parameter real VREF       = 3.3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                ldac,
    dac_multi_if.slave          bus,
    output logic                busy,
    output logic                ch_err,
    output logic [CH*WIDTH-1:0] code_out,
    output real                 a_out [CH]
);
    localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
`ifdef DAC_MIDSCALE_RESET_EN
    localparam logic [WIDTH-1:0] RST_CODE = {1'b1, {(WIDTH-1){1'b0}}};
`else
    localparam logic [WIDTH-1:0] RST_CODE = '0;
`endif

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            wr_acc, in_rng, load, upd;

    assign bus.in_ready = en;
    assign wr_acc = bus.in_valid & en;
    assign in_rng = int'(bus.in_ch) < CH;
    assign load   = en & ldac & (state == IDLE);
    assign upd    = en & (state == SETTLE) & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            ch_err <= 1'b0;
        end else begin
            if (wr_acc && !in_rng) ch_err <= 1'b1;
            case (state)
                IDLE: if (load) begin
                    state <= SETTLE;
                    cnt   <= CNTW'(SETTLE_CYC - 1);
                    busy  <= 1'b1;
                end
                SETTLE: if (en) begin
                    // Outputs refresh on the cycle the count is already zero.
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        dac_channel #(
            .WIDTH    (WIDTH),
            .VREF     (VREF),
            .RST_CODE (RST_CODE)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (wr_acc && in_rng && (int'(bus.in_ch) == c)),
            .wr_data (bus.in_data),
            .load    (load),
            .upd     (upd),
            .code    (code_out[c*WIDTH +: WIDTH]),
            .a_out   (a_out[c])
        );
    end
endmodule
